// File: rtl/rgb565_gray_stream_packer.sv
// Streaming RGB565 to 8-bit grayscale converter. Two arithmetic stages feed a byte packer
// that emits 32-bit words of four gray bytes, with partial words flushed at end of frame.
module rgb565_gray_stream_packer #(
    parameter int PIXELS_IN = 2,
    parameter int W_R       = 54,
    parameter int W_G       = 183,
    parameter int W_B       = 19
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [16*PIXELS_IN-1:0] s_data,
    input  logic                    s_last,
    input  logic                    cfg_thresh_en,
    input  logic [7:0]              cfg_thresh,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [31:0]             m_data,
    output logic [3:0]              m_keep,
    output logic                    m_last
);

    if (PIXELS_IN != 1 && PIXELS_IN != 2) begin : g_bad_pixels_in
        $error("PIXELS_IN must be 1 or 2");
    end
    if (W_R + W_G + W_B > 256) begin : g_bad_weights
        $error("W_R + W_G + W_B must not exceed 256");
    end

    localparam logic [8:0] WR = 9'(W_R);
    localparam logic [8:0] WG = 9'(W_G);
    localparam logic [8:0] WB = 9'(W_B);

    logic adv;

    // Stage 1: expand channels to 8 bits and form the weighted products.
    logic [PIXELS_IN-1:0][15:0] prod_r, prod_g, prod_b;
    logic [PIXELS_IN-1:0][15:0] s1_prod_r, s1_prod_g, s1_prod_b;
    logic                       s1_valid, s1_last;

    always_comb begin
        prod_r = '0;
        prod_g = '0;
        prod_b = '0;
        for (int k = 0; k < PIXELS_IN; k++) begin
            prod_r[k] = 16'(WR) * 16'({s_data[16*k+15 -: 5], s_data[16*k+15 -: 3]});
            prod_g[k] = 16'(WG) * 16'({s_data[16*k+10 -: 6], s_data[16*k+10 -: 2]});
            prod_b[k] = 16'(WB) * 16'({s_data[16*k+4  -: 5], s_data[16*k+4  -: 3]});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= s_valid;
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed alongside a cleared valid bit.
    always_ff @(posedge clock) begin
        if (adv) begin
            s1_last   <= s_last;
            s1_prod_r <= prod_r;
            s1_prod_g <= prod_g;
            s1_prod_b <= prod_b;
        end
    end

    // Stage 2: rounded sum, saturation and optional binarisation.
    logic [PIXELS_IN-1:0][16:0] sum;
    logic [PIXELS_IN-1:0][7:0]  luma;
    logic [PIXELS_IN-1:0][7:0]  gray;
    logic [PIXELS_IN-1:0][7:0]  s2_gray;
    logic                       s2_valid, s2_last;

    always_comb begin
        sum  = '0;
        luma = '0;
        gray = '0;
        for (int k = 0; k < PIXELS_IN; k++) begin
            sum[k]  = 17'(s1_prod_r[k]) + 17'(s1_prod_g[k]) + 17'(s1_prod_b[k]) + 17'd128;
            luma[k] = sum[k][16] ? 8'hFF : sum[k][15:8];
            if (cfg_thresh_en) begin
                gray[k] = (luma[k] >= cfg_thresh) ? 8'hFF : 8'h00;
            end else begin
                gray[k] = luma[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (adv) begin
            s2_last <= s1_last;
            s2_gray <= gray;
        end
    end

    // Packer: merge the beat into the accumulator at lane 'fill'.
    logic [31:0] acc;
    logic [2:0]  fill;
    logic [2:0]  new_fill;
    logic [31:0] merged;
    logic [3:0]  merged_keep;
    logic        flush;

    always_comb begin
        merged   = acc;
        new_fill = fill + 3'(PIXELS_IN);
        for (int lane = 0; lane < 4; lane++) begin
            for (int k = 0; k < PIXELS_IN; k++) begin
                if (lane == int'(fill) + k) begin
                    merged[8*lane +: 8] = s2_gray[k];
                end
            end
        end
        merged_keep = 4'((5'd1 << new_fill) - 5'd1);
        flush       = s2_valid && (new_fill >= 3'd4 || s2_last);
    end

    // The accumulator is zeroed on every flush so unused lanes of a partial word read as 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc  <= '0;
            fill <= '0;
        end else if (adv && s2_valid) begin
            if (flush) begin
                acc  <= '0;
                fill <= '0;
            end else begin
                acc  <= merged;
                fill <= new_fill;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (adv) begin
            m_valid <= flush;
            if (flush) begin
                m_data <= merged;
                m_keep <= merged_keep;
                m_last <= s2_last;
            end
        end
    end

    // A single stall signal freezes the whole pipeline, so no skid buffer is needed.
    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

endmodule
